// File: rtl/ing_oflow_pkg.sv
// Shared widths for the port receive path and the ingress overflow guard's state encoding.
// Latency: n/a (types and constants only). Backpressure: n/a.
package ing_oflow_pkg;

    localparam int PFW_SZ        = 32;
    localparam int RX_USG_SZ     = 9;
    localparam int RX_FIFO_DEPTH = 256;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        PASS = ST_PASS,
        DROP = ST_DROP
    } state_t;

    typedef struct packed {
        logic [PFW_SZ-1:0] dat;
        logic              commit;
        logic              abort;
    } slot_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ing_oflow.sv
// Admits whole packets into fifo_rx only when it has room; refused ones are dropped, runaways aborted (stats: ING_OFLOW_STATS_EN).
// Latency: 1 cycle from input transfer to p_srdy through a single output slot.
// Backpressure: c_drdy follows slot space and p_drdy; while dropping, input is consumed at full rate.
module ing_oflow
    import ing_oflow_pkg::*;
#(
    parameter int DEPTH     = RX_FIFO_DEPTH,
    parameter int MAX_WORDS = 200
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 c_srdy,
    output logic                 c_drdy,
    input  logic [PFW_SZ-1:0]    c_data,
    input  logic                 c_commit,
    input  logic                 c_abort,
    input  logic [RX_USG_SZ-1:0] rx_usage,
    output logic                 p_srdy,
    input  logic                 p_drdy,
    output logic [PFW_SZ-1:0]    p_data,
    output logic                 p_commit,
    output logic                 p_abort
`ifdef ING_OFLOW_STATS_EN
    ,
    output logic [15:0]          drop_cnt,
    output logic [15:0]          trunc_cnt
`endif
);

    localparam logic [RX_USG_SZ:0] DEPTH_W = (RX_USG_SZ+1)'(DEPTH);
    localparam logic [RX_USG_SZ:0] MAX_W   = (RX_USG_SZ+1)'(MAX_WORDS);
    localparam logic [8:0]         MAX_CNT = 9'(MAX_WORDS);

    state_t             state, state_nxt;
    slot_t              slot, slot_nxt;
    slot_t              in_word;
    logic               slot_vld, slot_vld_nxt;
    logic [7:0]         wcnt, wcnt_nxt;
    logic [8:0]         wcnt_inc;
    logic               xfer;
    logic               is_end;
    logic               drop_inc;
    logic               trunc_inc;
    logic [RX_USG_SZ:0] free;

    assign c_drdy   = (state == DROP) | ~slot_vld | p_drdy;
    assign xfer     = c_srdy & c_drdy;
    assign is_end   = c_commit | c_abort;
    assign in_word  = '{dat: c_data, commit: c_commit & ~c_abort, abort: c_abort};
    // The word still held in the slot is not yet reflected in rx_usage.
    assign free     = DEPTH_W - {1'b0, rx_usage} - {{RX_USG_SZ{1'b0}}, slot_vld};
    assign wcnt_inc = {1'b0, wcnt} + 9'd1;

    always_comb begin
        state_nxt    = state;
        slot_nxt     = slot;
        slot_vld_nxt = slot_vld & ~p_drdy;
        wcnt_nxt     = wcnt;
        drop_inc     = 1'b0;
        trunc_inc    = 1'b0;
        if (xfer) begin
            unique case (state)
                IDLE: begin
                    if (free >= MAX_W) begin
                        slot_nxt     = in_word;
                        slot_vld_nxt = 1'b1;
                        wcnt_nxt     = 8'd1;
                        state_nxt    = is_end ? IDLE : PASS;
                    end else begin
                        drop_inc  = 1'b1;
                        state_nxt = is_end ? IDLE : DROP;
                    end
                end
                PASS: begin
                    slot_nxt     = in_word;
                    slot_vld_nxt = 1'b1;
                    wcnt_nxt     = wcnt_inc[7:0];
                    if (is_end) begin
                        state_nxt = IDLE;
                    end else if (wcnt_inc == MAX_CNT) begin
                        // Runaway packet: close it as bad and swallow the remainder.
                        slot_nxt.abort = 1'b1;
                        trunc_inc      = 1'b1;
                        state_nxt      = DROP;
                    end
                end
                DROP: begin
                    if (is_end) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            slot     <= '0;
            slot_vld <= 1'b0;
            wcnt     <= 8'd0;
        end else begin
            state    <= state_nxt;
            slot     <= slot_nxt;
            slot_vld <= slot_vld_nxt;
            wcnt     <= wcnt_nxt;
        end
    end

    assign p_srdy   = slot_vld;
    assign p_data   = slot.dat;
    assign p_commit = slot.commit;
    assign p_abort  = slot.abort;

`ifdef ING_OFLOW_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt  <= 16'd0;
            trunc_cnt <= 16'd0;
        end else begin
            if (drop_inc)  drop_cnt  <= sat_inc(drop_cnt);
            if (trunc_inc) trunc_cnt <= sat_inc(trunc_cnt);
        end
    end
`else
    logic unused_stats;
    assign unused_stats = drop_inc | trunc_inc;
`endif

endmodule

// File: doc/ing_oflow.md
# ing_oflow

Ingress overflow guard for the port receive path. It sits between the concentrator output (`crx_*`) and the receive packet FIFO `fifo_rx` input. At each packet start it decides, from the FIFO's `rx_usage`, whether the whole packet can be admitted. It passes admitted packets with one cycle of register latency, silently drops refused ones, and aborts oversize packets so the FIFO never holds a partial or runaway packet; this is the receive-direction counterpart of `egr_oflow`.

## Interface
- `DEPTH`, default `RX_FIFO_DEPTH`: word capacity of the downstream FIFO.
- `MAX_WORDS`, default 200: largest legal packet in `PFW_SZ` words.
- `clk` in, 1: core clock.
- `reset` in, 1: synchronous, active-high.
- `c_srdy` in, 1: upstream word valid.
- `c_drdy` out, 1: upstream word accepted.
- `c_data` in, `PFW_SZ`: packet word.
- `c_commit` in, 1: with `c_srdy`, the word is the last of a good packet.
- `c_abort` in, 1: with `c_srdy`, the word is the last of a bad packet.
- `rx_usage` in, `RX_USG_SZ`: occupied words in `fifo_rx`.
- `p_srdy` out, 1: word to FIFO valid.
- `p_drdy` in, 1: FIFO accepts the word.
- `p_data` out, `PFW_SZ`: word.
- `p_commit` out, 1: end of a good packet.
- `p_abort` out, 1: end of a bad packet.
- `drop_cnt` out, 16: refused packets (only with `ING_OFLOW_STATS_EN`).
- `trunc_cnt` out, 16: oversize packets (only with `ING_OFLOW_STATS_EN`).

## Operation
- A transfer occurs on a cycle where `srdy` and `drdy` are both high. An end word is a word with `c_commit` or `c_abort` set. Both flags set at once counts as abort.
- States:
  - IDLE: at a packet boundary.
  - PASS: forwarding an admitted packet.
  - DROP: discarding the rest of a packet.
- Output register: one slot holding data, commit and abort.
  - `c_drdy = !p_srdy | p_drdy` in IDLE and PASS.
  - `c_drdy = 1` in DROP.
- Admission check, on the first word accepted in IDLE:
  - `free = DEPTH - rx_usage - p_srdy`, computed `RX_USG_SZ+1` bits wide and unsigned; the slot's word is not yet counted in `rx_usage`.
  - If `free >= MAX_WORDS`, load the word and go to PASS. A single-word packet, i.e. the first word is already an end word, returns to IDLE instead.
  - Otherwise discard the word, increment `drop_cnt`, and go to DROP. A single-word packet stays in IDLE.
- PASS:
  - `wcnt` (8 bits) counts words of the current packet, and the first word counts as 1.
  - An end word is loaded with its flags unchanged, and the state returns to IDLE.
  - If a non-end word brings `wcnt` to `MAX_WORDS`, it is loaded with `p_abort=1`, `trunc_cnt` increments, and the state goes to DROP.
  - An end word arriving exactly at `MAX_WORDS` is legal and passes with its own flags.
- DROP: consume every word. An end word returns the state to IDLE, and nothing is forwarded.
- Counters saturate at 16'hFFFF.
- Reset values: `p_srdy=0`, `p_commit=0`, `p_abort=0`, `p_data=0`, `c_drdy=1`, state IDLE, `wcnt=0`, `drop_cnt=0`, `trunc_cnt=0`.
- A reset in mid-packet discards the slot and returns to IDLE. `fifo_rx` is reset on the same `reset`.

## Timing
- Latency is 1 cycle from input transfer to `p_srdy`.
- Sustains one word per cycle while `p_drdy` is held high.
- `p_srdy` holds, and the slot contents stay stable, until the word transfers.
- The admission decision uses `rx_usage` sampled in the same cycle as the first-word transfer.
- `c_drdy` is combinational from `p_drdy` and state. No other combinational path runs input to output.
- DROP consumes at full rate regardless of `p_drdy`.

## Configuration
- `ING_OFLOW_STATS_EN` defined: the `drop_cnt` and `trunc_cnt` ports and their registers exist.
- `ING_OFLOW_STATS_EN` undefined: the ports and registers are absent, and data-path behaviour is identical.

## Structure
- Shared package or defines file:
  - `PFW_SZ`, `RX_USG_SZ` and `RX_FIFO_DEPTH`, already shared with the rest of the bridge.
  - The state encoding IDLE/PASS/DROP, as 2-bit localparams.
- No sub-module; the single output register is written inline.
- Instantiated in the port macro between `con` and `fifo_rx`, replacing the direct `crx_*` connection.

## Test plan
- Admit: `rx_usage=0`, `DEPTH=256`, 10-word packet with commit on word 10, `p_drdy=1` → 10 words out, last with `p_commit=1`, 1-cycle latency, `drop_cnt=0`.
- Refuse: `rx_usage=DEPTH-MAX_WORDS+1` → whole packet consumed at full rate, no `p_srdy`, `drop_cnt=1`; the next packet with `rx_usage=0` is admitted.
- Boundary space: `rx_usage=DEPTH-MAX_WORDS` with `p_srdy=0` → admitted. The same usage with a word still in the slot → refused.
- Oversize: `MAX_WORDS=200`, 205-word packet → 200 words forwarded, word 200 carries `p_abort=1`, words 201-205 dropped, `trunc_cnt=1`. A 200-word packet with commit passes clean.
- Backpressure: random `p_drdy` with 30% low → no word lost or duplicated, and `p_data` stays stable while stalled.
- Reset at word 5 of 10 → outputs at reset values next cycle, and a new packet after reset is admitted normally.
